// File: rtl/frame_scan_pkg.sv
// rtl/frame_scan_pkg.sv - shared state encoding and sizing helpers for the frame scan controller
package frame_scan_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HBLANK = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam int FCNT_W_DEF = 16;

    // One counter serves both blanking and drain, so size it for the larger of the two.
    function automatic int scan_cnt_w(input int hblank, input int rd_lat);
        int m;
        m = (hblank > rd_lat) ? hblank : rd_lat;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scan_valid_pipe.sv
// rtl/scan_valid_pipe.sv - read-latency valid shift register with synchronous flush
module scan_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic flush,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] pipe;

    // Shift issued reads through the memory latency; flush drops every in-flight pixel.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pipe <= '0;
        end else if (flush) begin
            pipe <= '0;
        end else begin
            pipe <= (pipe << 1) | DEPTH'(in_valid);
        end
    end

    assign out_valid = pipe[DEPTH-1];

endmodule

// File: rtl/frame_scan_ctrl.sv
// rtl/frame_scan_ctrl.sv - frame sequencer for the filter read path; optional FRAME_SCAN_CTRL_CONT_EN
module frame_scan_ctrl
    import frame_scan_pkg::*;
#(
    parameter int IMG_W  = 480,
    parameter int IMG_H  = 272,
    parameter int HBLANK = 4,
    parameter int RD_LAT = 2,
    parameter int FCNT_W = FCNT_W_DEF
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    input  logic              at_row_end,
    input  logic              last_row,
    input  logic              frame_done_pulse,
`ifdef FRAME_SCAN_CTRL_CONT_EN
    input  logic              auto_run,
`endif
    output logic              step_en,
    output logic              gen_clr,
    output logic              pix_valid,
    output logic              busy,
    output logic              done,
    output logic              sync_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int                CNT_W   = scan_cnt_w(HBLANK, RD_LAT);
    localparam logic [CNT_W-1:0] HB_LOAD = CNT_W'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [CNT_W-1:0] DR_LOAD = CNT_W'(RD_LAT - 1);

    if (RD_LAT < 1 || HBLANK < 0) begin : g_bad_timing
        $error("frame_scan_ctrl: RD_LAT must be >= 1 and HBLANK >= 0");
    end
    if (IMG_W < 1 || IMG_H < 1) begin : g_bad_geometry
        $error("frame_scan_ctrl: IMG_W and IMG_H must be >= 1");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             kill;
    logic             start_ok;
    logic             drain_first;
    logic             drain_last;
    logic             cont;

`ifdef FRAME_SCAN_CTRL_CONT_EN
    assign cont = auto_run;
`else
    assign cont = 1'b0;
`endif

    assign busy        = (state != ST_IDLE);
    assign kill        = abort && busy;
    assign gen_clr     = kill;
    assign step_en     = (state == ST_RUN) && out_ready && !abort;
    assign start_ok    = start && !abort && !busy;
    assign drain_first = (state == ST_DRAIN) && (cnt == DR_LOAD);
    assign drain_last  = (state == ST_DRAIN) && (cnt == '0);

    // Next-state and shared blank/drain counter; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (kill) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step_en && at_row_end) begin
                        if (last_row) begin
                            state_nxt = ST_DRAIN;
                            cnt_nxt   = DR_LOAD;
                        end else if (HBLANK != 0) begin
                            state_nxt = ST_HBLANK;
                            cnt_nxt   = HB_LOAD;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (cnt == '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == '0) begin
                        state_nxt = cont ? ST_RUN : ST_IDLE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Completion pulse and frame counter fire together when the drain expires.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= drain_last && !kill;
            if (drain_last && !kill) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Generator wrap must coincide with the first drain cycle; any disagreement latches until a new start.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync_err <= 1'b0;
        end else if (start_ok) begin
            sync_err <= 1'b0;
        end else if (!kill && (frame_done_pulse != drain_first)) begin
            sync_err <= 1'b1;
        end
    end

    scan_valid_pipe #(
        .DEPTH(RD_LAT)
    ) u_valid_pipe (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .flush    (kill),
        .in_valid (step_en),
        .out_valid(pix_valid)
    );

endmodule

// File: doc/frame_scan_ctrl.md
Name: frame_scan_ctrl

Overview:
- Frame-level sequencer for the image-filter read path.
- Drives the raster address generator's step_en, inserts horizontal blanking after each row so line buffers can rotate, and honours downstream backpressure.
- Drains the frame-memory read latency, then reports frame completion.
- Sits between the host/top-level control (start/abort) and the address generator + filter pipeline.

Parameters:
- IMG_W, 480, pixels per row (informational; row end comes from generator status).
- IMG_H, 272, rows per frame (informational).
- HBLANK, 4, idle cycles inserted after every non-final row; 0 = none.
- RD_LAT, 2, frame-memory read latency in cycles, ≥1.
- FCNT_W, 16, frame counter width.

Ports:
- iClk  in  1  clock.
- iRst_n  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse: begin a frame.
- abort  in  1  level/pulse: cancel the current frame.
- out_ready  in  1  downstream filter can accept pixels.
- at_row_end  in  1  generator status: current column is the last.
- last_row  in  1  generator status: current row is the last.
- frame_done_pulse  in  1  generator wrap pulse.
- step_en  out  1  advance generator / issue memory read.
- gen_clr  out  1  1-cycle synchronous clear to the generator.
- pix_valid  out  1  read data valid at the filter input.
- busy  out  1  state ≠ IDLE.
- done  out  1  1-cycle frame-complete pulse.
- sync_err  out  1  sticky generator/controller mismatch.
- frame_cnt  out  FCNT_W  completed frames.

Behaviour:
- Reset values: all outputs 0; frame_cnt = 0; state IDLE; blank counter 0; valid pipe empty.
- States: IDLE, RUN, HBLANK, DRAIN.
- step_en is combinational: state==RUN && out_ready && !abort.
- pix_valid = step_en delayed exactly RD_LAT cycles through a shift register.
- Backpressure: stepping stops the cycle out_ready falls. Downstream must absorb up to RD_LAT in-flight pixels.
- IDLE:
  - start → RUN next cycle.
  - start while busy is ignored.
- RUN:
  - step_en && at_row_end && !last_row → HBLANK with counter = HBLANK-1. If HBLANK==0, stay in RUN.
  - step_en && at_row_end && last_row → DRAIN, counter = RD_LAT-1.
- HBLANK: step_en = 0; decrement counter; at 0 → RUN.
- DRAIN: step_en = 0; decrement counter; at 0 → IDLE.
  - done registered high in the first IDLE cycle.
  - frame_cnt increments in the same cycle and wraps modulo 2^FCNT_W.
- Generator check:
  - frame_done_pulse must arrive exactly in the first DRAIN cycle (one cycle after the final step).
  - Arriving at any other time, or absent in that cycle, sets sync_err.
  - sync_err clears only on an accepted start.
- abort has priority over everything:
  - Any non-IDLE state → IDLE next cycle.
  - gen_clr pulses the same cycle abort is sampled while busy.
  - valid pipe flushed (pix_valid 0 from next cycle).
  - No done pulse; frame_cnt unchanged.
  - start && abort in the same cycle: abort wins and the frame does not start.
  - abort in IDLE: no effect, no gen_clr.
- Asynchronous reset mid-frame: immediate return to reset values. The generator shares iRst_n, so the two stay aligned.

Optional Feature:
- Macro FRAME_SCAN_CTRL_CONT_EN.
- Defined:
  - Adds input auto_run (1 bit).
  - On DRAIN expiry with auto_run=1, go directly to RUN instead of IDLE. done still pulses and frame_cnt still increments; busy stays 1.
  - abort behaviour unchanged.
- Not defined: port absent; every frame needs a new start.

Decomposition:
- Package frame_scan_pkg holds:
  - state encoding constants (2-bit: IDLE=0, RUN=1, HBLANK=2, DRAIN=3);
  - counter width derivation (clog2 of max(HBLANK, RD_LAT)+1);
  - FCNT_W default.
- One sub-module, scan_valid_pipe: RD_LAT-deep valid shift register with synchronous flush. Everything else stays in the top FSM.

Test Plan:
- Bench config: IMG_W=4, IMG_H=3, HBLANK=2, RD_LAT=2, with the raster address generator instance; out_ready=1 throughout unless stated.
- Nominal frame: start at cycle 0 → step_en cycles 1-4, 7-10, 13-16; HBLANK 5-6 and 11-12; pix_valid cycles 3-6, 9-12, 15-18; done at 19, busy low at 19, frame_cnt=1, sync_err=0.
- Backpressure: out_ready low cycles 2-4 → no step_en those cycles; 12 steps total; done delayed by 3 cycles (cycle 22); pixel order unchanged.
- Abort in cycle 8 → gen_clr=1 in cycle 8; IDLE at 9; pix_valid 0 from cycle 9; no done; frame_cnt unchanged; a new start gives the full 12-step frame from address 0.
- Corner cases:
  - start+abort in the same cycle → stays IDLE.
  - start at cycle 5 mid-frame → ignored.
  - frame_done_pulse forced at cycle 6 → sync_err=1, cleared by the next start.
- FRAME_SCAN_CTRL_CONT_EN defined, auto_run=1 → DRAIN ends in RUN; step_en resumes at cycle 19 with done=1 the same cycle; frame_cnt=2 after the second frame; busy never drops.
